// File: rtl/button_event_arbiter.sv
// Front-panel button arbiter: samples synchronized buttons on a slow tick, turns
// presses and long-presses into pending requests and drains them round-robin into an event FIFO.

module button_event_lane #(
  parameter int LONG_TICKS = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_sync,
  output logic o_press,
  output logic o_long
);
  localparam int HW = $clog2(LONG_TICKS + 1);

  logic          r_level;
  logic [HW-1:0] r_hold;

  // Long fires on the tick that moves the counter onto LONG_TICKS; saturation blocks repeats.
  assign o_press = i_tick & i_sync & ~r_level;
  assign o_long  = i_tick & i_sync & r_level & (r_hold == HW'(LONG_TICKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= 1'b0;
      r_hold  <= '0;
    end else if (i_tick) begin
      r_level <= i_sync;
      if (!i_sync)
        r_hold <= '0;
      else if (r_level && (r_hold != HW'(LONG_TICKS)))
        r_hold <= r_hold + 1'b1;
    end
  end
endmodule

module button_event_arbiter #(
  parameter int N_BTN      = 5,
  parameter int TICK_DIV   = 1000000,
  parameter int LONG_TICKS = 50,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_btn,
  output logic                     evt_long,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic                     tick
);
  localparam int BW = $clog2(N_BTN);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef struct packed {
    logic [BW-1:0] btn;
    logic          lng;
  } evt_t;

  logic [N_BTN-1:0] r_sync1, r_sync2;
  logic [TW-1:0]    r_tcnt;
  logic             w_tick;
  logic [N_BTN-1:0] w_set_s, w_set_l, w_clr_s, w_clr_l, w_req;
  logic [N_BTN-1:0] r_pend_s, r_pend_l;
  logic [BW-1:0]    r_rr, w_gnt_idx, w_cand, w_rr_nxt;
  logic             w_gnt_vld, w_kind_l, w_push, w_pop, w_full, w_drop;
  int               w_idx;
  evt_t             r_mem [FIFO_DEPTH];
  evt_t             w_push_evt;
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_tcnt  <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_tcnt  <= w_tick ? '0 : r_tcnt + 1'b1;
    end
  end

  assign w_tick = (r_tcnt == TW'(TICK_DIV - 1));
  assign tick   = w_tick;

  for (genvar g = 0; g < N_BTN; g++) begin : g_lane
    button_event_lane #(.LONG_TICKS(LONG_TICKS)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_tick  (w_tick),
      .i_sync  (r_sync2[g]),
      .o_press (w_set_s[g]),
      .o_long  (w_set_l[g])
    );
  end

  assign w_req  = r_pend_s | r_pend_l;
  assign w_full = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = evt_valid & evt_ready;

  // Scan from rr_ptr upward with wrap; first requester wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    w_cand    = '0;
    for (int k = 0; k < N_BTN; k++) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= N_BTN) w_idx = w_idx - N_BTN;
      w_cand = BW'(w_idx);
      if (!w_gnt_vld && w_req[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_kind_l   = r_pend_l[w_gnt_idx];
  assign w_push     = w_gnt_vld & ~w_full;
  assign w_push_evt = '{btn: w_gnt_idx, lng: w_kind_l};
  assign w_rr_nxt   = (w_gnt_idx == BW'(N_BTN - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_comb begin
    w_clr_s = '0;
    w_clr_l = '0;
    if (w_push) begin
      if (w_kind_l) w_clr_l[w_gnt_idx] = 1'b1;
      else          w_clr_s[w_gnt_idx] = 1'b1;
    end
  end

  // A new event landing on a still-pending bit that is not being drained is lost.
  assign w_drop = |((w_set_s & r_pend_s & ~w_clr_s) | (w_set_l & r_pend_l & ~w_clr_l));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_s <= '0;
      r_pend_l <= '0;
      r_rr     <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_pend_s <= (r_pend_s & ~w_clr_s) | w_set_s;
      r_pend_l <= (r_pend_l & ~w_clr_l) | w_set_l;
      if (w_push) r_rr <= w_rr_nxt;
      if (w_drop)       r_ovf <= 1'b1;
      else if (ovf_clr) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_push_evt;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign evt_valid = (r_cnt != '0);
  assign evt_btn   = r_mem[r_rp].btn;
  assign evt_long  = r_mem[r_rp].lng;
  assign ovf       = r_ovf;
endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Shares one command interface between N front-panel buttons.
- Samples synchronized buttons on a slow tick, detects presses and long-presses, and holds them as pending requests.
- Grants pending requests round-robin into a small event FIFO.
- Delivers FIFO events to the top-level FSM over a valid/ready handshake.

Parameters:
- N_BTN, 5, number of buttons (2..8).
- TICK_DIV, 1000000, clk cycles per sample tick; the bench uses 4.
- LONG_TICKS, 50, ticks a button must stay held to raise a long-press event.
- FIFO_DEPTH, 4, event FIFO entries; power of 2, at least 2.
- Local: BW = clog2(N_BTN).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- btn  in  N_BTN  raw button levels, asynchronous to clk.
- evt_valid  out  1  FIFO head holds an event.
- evt_ready  in  1  consumer accepts the head this cycle.
- evt_btn  out  BW  button index of the head event.
- evt_long  out  1  head is a long-press (1) or a short press (0).
- ovf  out  1  sticky: an event was dropped.
- ovf_clr  in  1  clears ovf.
- tick  out  1  one-cycle sample strobe (debug/status).

Behaviour:
- Reset:
  - rst=1 asynchronously clears all state: tick counter, synchronizers, levels, hold counters, pending bits, rr_ptr, FIFO pointers and count, ovf.
  - Outputs after reset: evt_valid=0, evt_btn=0, evt_long=0, ovf=0, tick=0.
  - Reset mid-operation discards queued and pending events. evt_valid falls asynchronously.
- Synchronizer: btn passes through 2 flops to give sync[i].
- Tick generation:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 exactly in the cycle where the counter equals TICK_DIV-1.
- Per-button sampling, updated only in tick cycles:
  - level[i] <= sync[i].
  - Press event: sync[i]=1 and level[i]=0.
  - Hold counter:
    - Cleared when sync[i]=0.
    - Increments while sync[i]=1 and level[i]=1, saturating at LONG_TICKS.
  - Long event fires once, on the tick where the hold counter transitions to LONG_TICKS. There is no further long event until release.
  - Release produces no event.
- Pending bits pend_s[i] and pend_l[i]:
  - Next value = (pend & ~clr) | set.
  - When a set and a clear hit the same bit in the same cycle, the bit stays set (the new event is kept).
  - If an event arrives while its pending bit is already 1 and not being cleared that cycle, the event is dropped and ovf is set.
- Arbiter (combinational grant, registered effect):
  - req[i] = pend_s[i] | pend_l[i].
  - When req != 0 and FIFO count < FIFO_DEPTH, grant the first requester at or after rr_ptr, wrapping at N_BTN.
  - For the granted button, a long event is pushed before a short one; the other kind stays pending.
  - On grant, push {i, kind}, clear that pending bit, and set rr_ptr <= (i+1) mod N_BTN.
  - At most one push per cycle. No push when full, even if a pop occurs in the same cycle.
- FIFO and handshake:
  - Pop when evt_valid & evt_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - evt_btn and evt_long are stable while evt_valid=1 and evt_ready=0.
  - evt_btn and evt_long are don't-care when evt_valid=0; they must not be X.
- Latency, for an empty FIFO and no competing requests:
  - Tick cycle T: pending is set at the end of T.
  - Push happens at the end of T+1.
  - evt_valid=1 in cycle T+2.
- ovf:
  - Set by any dropped event.
  - ovf_clr=1 clears it on the next edge.
  - If set and clear occur in the same cycle, set wins.

Test Plan:
- Single press: TICK_DIV=4; raise btn[2] and hold 3 ticks, evt_ready=1 -> exactly one event {evt_btn=2, evt_long=0}, with evt_valid rising 2 cycles after the sampling tick. No event on release.
- Long press: LONG_TICKS=5; hold btn[0] for 8 ticks -> short event, then one long event on the 6th held tick ({0,1}), then nothing more until release and re-press.
- Round-robin fairness: btn[1], btn[3] and btn[4] pressed on the same tick with rr_ptr=2 -> output order 3, 4, 1. A later simultaneous press of 1 and 4 -> order 4, 1 (rr_ptr=2 after granting 1).
- Back-pressure and overflow: evt_ready=0; press buttons 0..4 once each on separate ticks -> 4 events queued and 1 left pending. Re-press that pending button -> ovf=1. Release evt_ready -> 5 events in order. ovf_clr pulse -> ovf=0.
- Stall stability: evt_ready=0 for 10 cycles with evt_valid=1 -> evt_btn and evt_long unchanged. Then one ready cycle pops exactly one entry.
- Async reset mid-stream: assert rst between clock edges with 3 events queued -> evt_valid=0 and ovf=0 immediately. After release, no stale events appear and the tick counter restarts from 0.
